argmax_sequencer: RTL and testbench

- Sequential argmax controller for the classifier output layer.
- Accepts NUM_CLASSES class scores streamed one per beat over a valid/ready handshake and keeps a running maximum and its index.
- Reports the winning class index once per classification, with a one-cycle Done pulse.
- Replaces the 10-wide combinational max tree: one comparator, time-shared across all beats.

---
 rtl/argmax_sequencer_pkg.sv | 21 ++
 rtl/argmax_sequencer_if.sv | 25 ++
 rtl/argmax_cmp.sv | 34 +++
 rtl/argmax_sequencer.sv | 114 +++++++++++
 tb/tb_argmax_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/argmax_sequencer_pkg.sv
// argmax_sequencer_pkg: FSM encoding, default sizes and index-width helper.
// Build option ARGMAX_SIGNED_EN selects signed score comparison.
package argmax_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

  localparam int NUM_SIZE_DEF    = 26;
  localparam int NUM_CLASSES_DEF = 10;

  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/argmax_sequencer_if.sv
// argmax_sequencer_if: score stream valid/ready bundle.
// Master drives scores; slave is the argmax sequencer.
interface argmax_sequencer_if
  import argmax_sequencer_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEF
);

  logic [NUM_SIZE-1:0] ScoreIn;
  logic                ScoreValid;
  logic                ScoreReady;

  modport master (
    output ScoreIn,
    output ScoreValid,
    input  ScoreReady
  );

  modport slave (
    input  ScoreIn,
    input  ScoreValid,
    output ScoreReady
  );

endinterface

// File: rtl/argmax_cmp.sv
// argmax_cmp: greater-than compare plus select-or-keep for max and index.
// ARGMAX_SIGNED_EN makes the compare two's complement.
module argmax_cmp #(
  parameter int NUM_SIZE = 26,
  parameter int IDX_W    = 4
) (
  input  logic                first,
  input  logic [NUM_SIZE-1:0] score,
  input  logic [IDX_W-1:0]    beat,
  input  logic [NUM_SIZE-1:0] cur_max,
  input  logic [IDX_W-1:0]    cur_idx,
  output logic [NUM_SIZE-1:0] nxt_max,
  output logic [IDX_W-1:0]    nxt_idx
);

  logic gt;

`ifdef ARGMAX_SIGNED_EN
  assign gt = $signed(score) > $signed(cur_max);
`else
  assign gt = score > cur_max;
`endif

  // strict compare keeps the lowest index on ties
  always_comb begin
    nxt_max = cur_max;
    nxt_idx = cur_idx;
    if (first || gt) begin
      nxt_max = score;
      nxt_idx = beat;
    end
  end

endmodule

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: streamed argmax over NUM_CLASSES scores, one compare per beat.
// Build option ARGMAX_SIGNED_EN selects signed score comparison.
module argmax_sequencer
  import argmax_sequencer_pkg::*;
#(
  parameter int NUM_SIZE    = NUM_SIZE_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int IDX_W       = idx_w(NUM_CLASSES)
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic                Start,
  input  logic                Abort,
  argmax_sequencer_if.slave   sif,
  output logic [IDX_W-1:0]    Index,
  output logic [NUM_SIZE-1:0] MaxScore,
  output logic                Done,
  output logic                Busy
);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    beat;
  logic [NUM_SIZE-1:0] run_max;
  logic [IDX_W-1:0]    run_idx;
  logic [NUM_SIZE-1:0] max_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NUM_SIZE-1:0] cmp_max;
  logic [IDX_W-1:0]    cmp_idx;
  logic                take;
  logic                last;
  logic                launch;

  assign take   = sif.ScoreValid && sif.ScoreReady;
  assign last   = beat == IDX_W'(NUM_CLASSES - 1);
  assign launch = (state == ST_IDLE) && Start && !Abort;

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (launch) state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (Abort)             state_nxt = ST_IDLE;
        else if (take && last) state_nxt = ST_REPORT;
      end
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Abort masks the beat and the Done pulse in the same cycle
  always_comb begin
    sif.ScoreReady = 1'b0;
    Busy           = 1'b0;
    Done           = 1'b0;
    unique case (state)
      ST_COLLECT: begin
        sif.ScoreReady = !Abort;
        Busy           = 1'b1;
      end
      ST_REPORT: begin
        Busy = 1'b1;
        Done = !Abort;
      end
      default: ;
    endcase
  end

  argmax_cmp #(
    .NUM_SIZE (NUM_SIZE),
    .IDX_W    (IDX_W)
  ) u_cmp (
    .first   (beat == '0),
    .score   (sif.ScoreIn),
    .beat    (beat),
    .cur_max (run_max),
    .cur_idx (run_idx),
    .nxt_max (cmp_max),
    .nxt_idx (cmp_idx)
  );

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      beat    <= '0;
      run_max <= '0;
      run_idx <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      if (launch)    beat <= '0;
      else if (take) beat <= beat + 1'b1;
      if (take) begin
        run_max <= cmp_max;
        run_idx <= cmp_idx;
      end
      if (Done) begin
        max_q <= run_max;
        idx_q <= run_idx;
      end
    end
  end

  // the result shows up during the report cycle itself
  assign Index    = Done ? run_idx : idx_q;
  assign MaxScore = Done ? run_max : max_q;

endmodule

// File: tb/tb_argmax_sequencer.sv
// tb_argmax_sequencer: directed scenarios for argmax_sequencer.
// Expected results follow the ARGMAX_SIGNED_EN build setting.
module tb_argmax_sequencer;

  logic        clk = 1'b0;
  logic        GlobalReset;
  logic        Start;
  logic        Abort;
  logic [3:0]  Index;
  logic [25:0] MaxScore;
  logic        Done;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  argmax_sequencer_if sif ();

  argmax_sequencer dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .Start       (Start),
    .Abort       (Abort),
    .sif         (sif),
    .Index       (Index),
    .MaxScore    (MaxScore),
    .Done        (Done),
    .Busy        (Busy)
  );

  always #5 clk = ~clk;

  // Full classification; junk stays valid after the last beat to expose extra takes
  task automatic run_scores(
    input  logic [25:0] s [10],
    input  bit          stall,
    input  bit          start_mid,
    output int          done_cyc,
    output int          done_cnt,
    output int          beats,
    output logic [3:0]  idx_at_done,
    output logic [25:0] max_at_done
  );
    int cyc;
    int k;
    cyc = 0;
    k = 0;
    done_cyc = -1;
    done_cnt = 0;
    idx_at_done = 'x;
    max_at_done = 'x;
    @(posedge clk); #1 Start = 1'b1;
    @(posedge clk); #1 Start = 1'b0;
    while (cyc < 60) begin
      sif.ScoreValid = !(stall && (cyc % 2 == 1));
      sif.ScoreIn    = (k < 10) ? s[k] : 26'h3FFFFFF;
      Start          = start_mid && (cyc == 3);
      @(negedge clk);
      if (Done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc    = cyc + 1;
          idx_at_done = Index;
          max_at_done = MaxScore;
        end
      end
      if (sif.ScoreValid && sif.ScoreReady) k++;
      @(posedge clk); #1;
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
    end
    sif.ScoreValid = 1'b0;
    Start = 1'b0;
    beats = k;
  endtask

  task automatic test_reset;
    GlobalReset = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    sif.ScoreValid = 1'b0;
    sif.ScoreIn = '0;
    #2;
    n_checks++;
    if ({Index, MaxScore, Done, Busy, sif.ScoreReady} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got idx=%0d max=%0d done=%b busy=%b rdy=%b, want all 0",
               Index, MaxScore, Done, Busy, sif.ScoreReady);
    end
    @(negedge clk);
    GlobalReset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0 || sif.ScoreReady !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b rdy=%b, want 0 0", Busy, sif.ScoreReady);
    end
  endtask

  task automatic test_basic;
    logic [25:0] s [10];
    int dc, dn, bt;
    logic [3:0] ix;
    logic [25:0] mx;
    s = '{26'd5, 26'd9, 26'd3, 26'd12, 26'd1, 26'd0, 26'd7, 26'd12, 26'd2, 26'd4};
    run_scores(s, 1'b0, 1'b0, dc, dn, bt, ix, mx);
    n_checks++;
    if (dc !== 11) begin
      n_fail++;
      $display("FAIL basic_latency: done at cycle %0d, want 11", dc);
    end
    n_checks++;
    if (dn !== 1 || bt !== 10) begin
      n_fail++;
      $display("FAIL basic_pulse: done_cnt=%0d beats=%0d, want 1 10", dn, bt);
    end
    n_checks++;
    if (ix !== 4'd3 || mx !== 26'd12) begin
      n_fail++;
      $display("FAIL basic_at_done: idx=%0d max=%0d, want 3 12", ix, mx);
    end
    n_checks++;
    if (Index !== 4'd3 || MaxScore !== 26'd12 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_held: idx=%0d max=%0d busy=%b, want 3 12 0", Index, MaxScore, Busy);
    end
  endtask

  task automatic test_all_zero;
    logic [25:0] s [10];
    int dc, dn, bt;
    logic [3:0] ix;
    logic [25:0] mx;
    foreach (s[i]) s[i] = '0;
    run_scores(s, 1'b0, 1'b0, dc, dn, bt, ix, mx);
    n_checks++;
    if (dn !== 1 || ix !== 4'd0 || mx !== 26'd0) begin
      n_fail++;
      $display("FAIL all_zero: done_cnt=%0d idx=%0d max=%0d, want 1 0 0", dn, ix, mx);
    end
  endtask

  task automatic test_stall;
    logic [25:0] s [10];
    int dc, dn, bt;
    logic [3:0] ix;
    logic [25:0] mx;
    foreach (s[i]) s[i] = 26'(i + 1);
    run_scores(s, 1'b1, 1'b1, dc, dn, bt, ix, mx);
    n_checks++;
    if (dc !== 20 || dn !== 1) begin
      n_fail++;
      $display("FAIL stall_timing: done at %0d cnt=%0d, want 20 1", dc, dn);
    end
    n_checks++;
    if (bt !== 10) begin
      n_fail++;
      $display("FAIL stall_beats: beats=%0d, want 10", bt);
    end
    n_checks++;
    if (ix !== 4'd9 || mx !== 26'd10) begin
      n_fail++;
      $display("FAIL stall_result: idx=%0d max=%0d, want 9 10", ix, mx);
    end
  endtask

  task automatic test_abort;
    logic [25:0] s [10];
    int dc, dn, bt;
    logic [3:0] ix;
    logic [25:0] mx;
    dn = 0;
    @(posedge clk); #1 Start = 1'b1;
    @(posedge clk); #1 Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sif.ScoreValid = 1'b1;
      sif.ScoreIn = 26'd100 + 26'(i);
      @(negedge clk);
      if (Done) dn++;
      @(posedge clk); #1;
    end
    Abort = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sif.ScoreReady !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_cycle: rdy=%b busy=%b done=%b, want 0 1 0",
               sif.ScoreReady, Busy, Done);
    end
    @(posedge clk); #1;
    Abort = 1'b0;
    sif.ScoreValid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0 || Index !== 4'd9 || MaxScore !== 26'd10 || dn !== 0) begin
      n_fail++;
      $display("FAIL abort_held: busy=%b idx=%0d max=%0d dn=%0d, want 0 9 10 0",
               Busy, Index, MaxScore, dn);
    end
    @(posedge clk); #1;
    Abort = 1'b1;
    Start = 1'b1;
    @(posedge clk); #1;
    Abort = 1'b0;
    Start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start_idle: busy=%b, want 0", Busy);
    end
    s = '{26'd3, 26'd8, 26'd2, 26'd8, 26'd5, 26'd1, 26'd20, 26'd19, 26'd0, 26'd20};
    run_scores(s, 1'b0, 1'b0, dc, dn, bt, ix, mx);
    n_checks++;
    if (dn !== 1 || ix !== 4'd6 || mx !== 26'd20) begin
      n_fail++;
      $display("FAIL abort_rerun: cnt=%0d idx=%0d max=%0d, want 1 6 20", dn, ix, mx);
    end
  endtask

  task automatic test_reset_mid;
    logic [25:0] s [10];
    int dc, dn, bt;
    logic [3:0] ix;
    logic [25:0] mx;
    @(posedge clk); #1 Start = 1'b1;
    @(posedge clk); #1 Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sif.ScoreValid = 1'b1;
      sif.ScoreIn = 26'd50 + 26'(i);
      @(posedge clk); #1;
    end
    sif.ScoreIn = 26'd77;
    #2 GlobalReset = 1'b0;
    #1;
    n_checks++;
    if ({Index, MaxScore, Done, Busy, sif.ScoreReady} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: idx=%0d max=%0d done=%b busy=%b rdy=%b, want all 0",
               Index, MaxScore, Done, Busy, sif.ScoreReady);
    end
    sif.ScoreValid = 1'b0;
    @(negedge clk);
    GlobalReset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0 || Index !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b idx=%0d, want 0 0", Busy, Index);
    end
    foreach (s[i]) s[i] = 26'(i + 1);
    run_scores(s, 1'b0, 1'b0, dc, dn, bt, ix, mx);
    n_checks++;
    if (dc !== 11 || dn !== 1 || ix !== 4'd9 || mx !== 26'd10) begin
      n_fail++;
      $display("FAIL reset_rerun: dc=%0d cnt=%0d idx=%0d max=%0d, want 11 1 9 10",
               dc, dn, ix, mx);
    end
  endtask

  task automatic test_sign;
    logic [25:0] s [10];
    int dc, dn, bt;
    logic [3:0] ix;
    logic [25:0] mx;
    logic [3:0] want_ix;
    logic [25:0] want_mx;
`ifdef ARGMAX_SIGNED_EN
    want_ix = 4'd0;
    want_mx = 26'd1;
`else
    want_ix = 4'd2;
    want_mx = 26'h3FFFFFF;
`endif
    foreach (s[i]) s[i] = 26'd1;
    s[2] = 26'h3FFFFFF;
    run_scores(s, 1'b0, 1'b0, dc, dn, bt, ix, mx);
    n_checks++;
    if (ix !== want_ix || mx !== want_mx) begin
      n_fail++;
      $display("FAIL sign_compare: idx=%0d max=%h, want %0d %h", ix, mx, want_ix, want_mx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_zero();
    test_stall();
    test_abort();
    test_reset_mid();
    test_sign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
